// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Contents: FSM state encoding, requester IDs, default memory latency.
package mem_arb_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_e;

   localparam int unsigned DEF_LAT = 2;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter timing one memory transaction.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load LAT-1 (issue cycle)
//   dec_i        : decrement by one (saturates at zero)
//   zero_o       : next count value is zero
module lat_counter
   import mem_arb_defs::*;
#(
   parameter int unsigned LAT = DEF_LAT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int unsigned CW = $clog2(LAT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: load has priority over decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(LAT - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the cycle in which the countdown lands on zero.
   assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between instruction
// fetch (IF, read-only) and data access (DM, read/write); one transaction in
// flight, stalls derived from req & ~done.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   if_*                        : fetch request / completion / stall
//   dm_*                        : data request / completion / stall / dump
//   mem_*                       : memory issue strobe, command and read data
//   err_o                       : sticky protocol error
module mem_arbiter
   import mem_arb_defs::*;
#(
   parameter int unsigned LAT = DEF_LAT,
   parameter int unsigned AW  = 16,
   parameter int unsigned DW  = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_done_o,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_stall_o,
   input  logic          dm_req_i,
   input  logic          dm_wr_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   input  logic          dm_dump_i,
   output logic          dm_done_o,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_stall_o,
   output logic          mem_en_o,
   output logic          mem_wr_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_data_in_o,
   output logic          mem_dump_o,
   input  logic [DW-1:0] mem_data_out_i,
   output logic          err_o
);

   state_e        state_q, state_d;
   req_e          grant_q, grant_d;   // current grant, doubles as last_grant
   logic          err_q, err_d;
   logic          dump_pend_q, dump_pend_d;

   logic          if_elig, dm_elig, issue, quiet;
   req_e          win;
   logic [AW-1:0] raw_addr;
   logic          cnt_load, cnt_dec, cnt_zero;

   lat_counter #(.LAT(LAT)) u_lat_counter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   // Arbitration: the requester completing in RESP is masked out.
   always_comb begin
      if_elig = if_req_i & ~((state_q == RESP) & (grant_q == REQ_IF));
      dm_elig = dm_req_i & ~((state_q == RESP) & (grant_q == REQ_DM));
      issue   = ((state_q == IDLE) | (state_q == RESP)) & (if_elig | dm_elig);
      if (if_elig & dm_elig) begin
         win = (grant_q == REQ_IF) ? REQ_DM : REQ_IF;
      end else begin
         win = dm_elig ? REQ_DM : REQ_IF;
      end
      raw_addr = (win == REQ_DM) ? dm_addr_i : if_addr_i;
   end

   // Next state and memory/requester outputs.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      err_d         = err_q;
      dump_pend_d   = dump_pend_q;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      mem_en_o      = 1'b0;
      mem_wr_o      = 1'b0;
      mem_addr_o    = '0;
      mem_data_in_o = '0;
      mem_dump_o    = 1'b0;
      if_done_o     = 1'b0;
      dm_done_o     = 1'b0;
      if_rdata_o    = '0;
      dm_rdata_o    = '0;

      case (state_q)
         IDLE: ;
         BUSY: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_d = RESP;
            end
            // Granted requester abandoned its transaction.
            if ((grant_q == REQ_IF) ? ~if_req_i : ~dm_req_i) begin
               err_d = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (grant_q == REQ_IF) begin
               if_done_o  = 1'b1;
               if_rdata_o = mem_data_out_i;
            end else begin
               dm_done_o  = 1'b1;
               dm_rdata_o = mem_data_out_i;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         mem_en_o   = 1'b1;
         cnt_load   = 1'b1;
         grant_d    = win;
         state_d    = (LAT == 1) ? RESP : BUSY;
         mem_addr_o = {raw_addr[AW-1:1], 1'b0};
         if (raw_addr[0]) begin
            err_d = 1'b1;
         end
         if (win == REQ_DM) begin
            mem_wr_o      = dm_wr_i;
            mem_data_in_o = dm_wdata_i;
         end
      end

      // Dump passes through only when the memory port is quiet.
      quiet = ((state_q == IDLE) | (state_q == RESP)) & ~issue;
      if (quiet) begin
         mem_dump_o  = dm_dump_i | dump_pend_q;
         dump_pend_d = 1'b0;
      end else if (dm_dump_i) begin
         dump_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         grant_q     <= REQ_IF;
         err_q       <= 1'b0;
         dump_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         err_q       <= err_d;
         dump_pend_q <= dump_pend_d;
      end
   end

   assign err_o      = err_q;
   assign if_stall_o = if_req_i & ~if_done_o;
   assign dm_stall_o = dm_req_i & ~dm_done_o;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency 16-bit memory between two requesters: instruction fetch (IF, read-only) and data memory access (DM, read/write).
- Replaces the separate instruction and data memories, so the processor uses one unified memory.
- Generates the stall signals the processor uses to freeze the PC and the pipeline.
- Allows only one transaction in flight at a time; arbitration is round-robin on ties.

Parameters:
- LAT, 2: memory read/write latency in cycles, counted from issue; must be at least 1.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request. Held high until if_done.
- if_addr  in  AW  fetch address.
- if_done  out  1  one-cycle completion pulse for the fetch.
- if_rdata  out  DW  fetch data. Valid only while if_done is high.
- if_stall  out  1  equals if_req & ~if_done.
- dm_req  in  1  data request. Held high until dm_done.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_dump  in  1  dump request, forwarded to memory.
- dm_done  out  1  one-cycle completion pulse for the data access.
- dm_rdata  out  DW  read data. Valid only while dm_done is high.
- dm_stall  out  1  equals dm_req & ~dm_done.
- mem_en  out  1  issue strobe to memory, one cycle per transaction.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  AW  address for the issued transaction.
- mem_data_in  out  DW  write data for the issued transaction.
- mem_dump  out  1  createdump to memory.
- mem_data_out  in  DW  memory read data. Valid exactly LAT cycles after mem_en.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - State is IDLE.
  - last_grant is IF, so the first tie goes to DM.
  - Latency counter is 0.
  - err is 0.
  - All outputs read 0: done, rdata, mem_en, mem_wr, mem_addr, mem_data_in and mem_dump.
- States:
  - IDLE: no transaction in flight.
  - BUSY: a transaction has been issued; the counter counts down LAT-1 cycles.
  - RESP: completion cycle.
- Issue:
  - In IDLE, or in RESP, the arbiter picks one eligible requester. It drives mem_en=1 with that requester's addr, wr and wdata combinationally in the same cycle (cycle T).
  - It records the grant and loads counter = LAT-1.
  - Next state is RESP if LAT=1, otherwise BUSY.
  - mem_wr is forced to 0 for IF grants.
- Arbitration:
  - A single requester wins outright.
  - When both request, the winner is the one that is not last_grant.
  - last_grant is updated on every issue.
- BUSY: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP (cycle T+LAT):
  - Assert the granted requester's done for exactly one cycle.
  - Its rdata equals mem_data_out, for both reads and writes; the value is undefined for writes.
  - The non-granted requester's done and rdata are held at 0.
- RESP, back-to-back issue:
  - The completing requester is masked from arbitration in its own RESP cycle, because its req is still high.
  - The other requester, if pending, issues in the same cycle.
  - Otherwise the next state is IDLE.
- Throughput:
  - With both requesters pending, grants alternate.
  - Each transaction occupies LAT cycles from issue to done.
- Address and data are sampled only at issue; they may change afterwards without effect.
- err (sticky until rst) is set in any of these cases:
  - The granted requester drops req before its done.
  - An odd address is presented while req is high and that requester is granted. The transaction still proceeds, with bit 0 forced to 0.
- mem_dump:
  - Equals dm_dump while in IDLE, or in RESP when nothing is issuing.
  - Otherwise it is held off until that condition holds. A pending dump is registered and asserted for exactly one cycle.
- Reset mid-transaction:
  - Return to IDLE immediately. No done is generated.
  - The memory's late response is ignored.
  - Requesters must re-request.

Decomposition:
- Shared package mem_arb_defs holds:
  - State encodings: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Requester IDs: REQ_IF=1'b0, REQ_DM=1'b1.
  - Default LAT.
- One sub-module, lat_counter: a loadable down-counter with a zero flag, width $clog2(LAT+1).

Test Plan:
- Lone fetch (LAT=2): if_req=1, if_addr=0x0010 at cycle 0 → mem_en=1 and mem_addr=0x0010 in cycle 0; if_done=1 with if_rdata=mem_data_out in cycle 2; if_stall high in cycles 0-1 and low in cycle 2.
- Tie after reset: if_req and dm_req both rise in cycle 0 (dm_wr=1, dm_addr=0x0100, dm_wdata=0xBEEF) → DM is issued in cycle 0 with mem_wr=1 and mem_data_in=0xBEEF; dm_done in cycle 2; IF is issued in cycle 2 with mem_wr=0; if_done in cycle 4.
- Continuous contention for 8 cycles → grant order DM, IF, DM, IF; no requester waits more than 2·LAT cycles.
- LAT=1 back-to-back IF: if_req held through four fetches → done pulses in cycles 1, 3, 5, 7, because of the RESP self-mask; mem_en is never high for the same requester in its own done cycle.
- Protocol errors: dm_req dropped in cycle 1 of a DM transaction → err=1 from cycle 2 until rst, and err stays 1 after further legal traffic. dm_addr=0x0101 → mem_addr=0x0100 and err=1.
- rst=1 in a BUSY cycle → the next cycle shows IDLE, with all done, mem_en and err at 0; a subsequent request completes normally LAT cycles after issue.
